bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) for the 32-bit up/down counter value.
- Sits directly downstream of the divided-clock counter stage.
- Runs on the fast system clock and samples the counter value only on a start request.
- Its packed BCD output feeds the 7-segment/display multiplexer stage.

Parameters:
- WIDTH, 32, binary input width; must be >= 4.
- DIGITS, 10, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH (10 for 32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request: sample value and begin conversion; honoured only when ready=1.
- value  input  WIDTH  binary operand (counter output); sampled on the accepting edge only.
- ready  output  1  high in IDLE; start is accepted only when ready=1.
- busy  output  1  high in SHIFT and DONE; always equals ~ready.
- valid  output  1  one-cycle pulse; bcd/neg carry a new result.
- bcd  output  4*DIGITS  packed result; digit 0 (units) in bcd[3:0]; held until next valid.
- neg  output  1  sign of last result; constant 0 when the optional feature is compiled out.

Behaviour:
- Reset (async assert, sync release): state=IDLE, ready=1, busy=0, valid=0, bcd=0, neg=0, all internal registers 0.
- FSM states are IDLE, SHIFT and DONE.
- IDLE -> SHIFT on the edge where start=1:
  - bin_reg <= operand (see Optional Feature);
  - acc <= 0;
  - cnt <= 0.
- SHIFT, each edge:
  - every acc digit >= 5 gets +3;
  - then {acc,bin_reg} shifts left 1;
  - cnt++.
  - On the edge with cnt==WIDTH-1, the final shift result is written to bcd, and state <= DONE.
- DONE: valid=1 for exactly this one cycle; next edge -> IDLE.
- Latency:
  - start accepted at edge E, valid high in the cycle after edge E+WIDTH (32 edges for the default).
  - Back-to-back conversions every WIDTH+2 cycles.
- start while busy=1 is ignored, not queued. value changes during SHIFT have no effect.
- bcd/neg change only on the edge entering DONE and are stable otherwise.
- Reset mid-conversion: the conversion is aborted, and outputs return to reset values immediately (asynchronously).
- Arithmetic: digit correction is a 4-bit unsigned add with no carry out (the input is 5..9, so the result is 8..12). acc width is exactly 4*DIGITS, and no overflow is possible given the DIGITS constraint.

Optional Feature:
- Macro: BIN2BCD_SIGNED_EN.
- Defined:
  - value is treated as two's complement;
  - at accept, neg <= value[WIDTH-1] (registered, published at DONE) and bin_reg <= magnitude;
  - -2^(WIDTH-1) converts as unsigned 2^(WIDTH-1), which is correct for the default width.
- Undefined: value is unsigned; neg is constant 0.
- Latency is identical in both builds.

Decomposition:
- Package bcd_pkg holds:
  - state_t enum (IDLE, SHIFT, DONE);
  - BCD_DIGIT_W=4 constant;
  - localparam helper for the cnt width, $clog2(WIDTH).
- One natural sub-module, bcd_add3: a combinational 4-bit digit-correction cell (in >= 5 ? in+3 : in), instantiated DIGITS times via generate.

Test Plan:
- value=0, start pulse -> valid after 32 edges, bcd=40'h0, neg=0.
- value=1234567890 -> bcd=40'h1234567890; value=32'hFFFFFFFF -> bcd=40'h4294967295 (unsigned build).
- Accept 100, then pulse start with value=7 at cycles 5 and 20 -> exactly one valid, bcd=40'h100; ready low for 33 cycles after accept.
- Assert rst at cycle 10 of a conversion of 999 -> busy=0, ready=1 and bcd=0 without a clock edge; no valid; a fresh start of 999 gives 40'h999.
- With BIN2BCD_SIGNED_EN:
  - 32'hFFFFFFFF -> neg=1, bcd=40'h1;
  - 32'h80000000 -> neg=1, bcd=40'h2147483648;
  - 42 -> neg=0, bcd=40'h42.
- Back-to-back: start held high continuously -> valid every 34 cycles, each result reflecting value at its accept edge.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional signed mode is selected in bin2bcd_seq by BIN2BCD_SIGNED_EN.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGIT_W = 4;

   // Bit-counter width; kept at least 1 so tiny widths still elaborate.
   function automatic int cnt_width(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Digit-correction cell for shift-and-add-3: digits 5..9 become 8..12 before the shift.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock (shift-and-add-3).
// Define BIN2BCD_SIGNED_EN to treat value as two's complement and report its sign on neg.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 10
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic [WIDTH-1:0]            value,
   output logic                        ready,
   output logic                        busy,
   output logic                        valid,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
   output logic                        neg
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam int ACC_W = BCD_DIGIT_W * DIGITS;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] bin_reg;
   logic [WIDTH-1:0] operand;
   logic [ACC_W-1:0] acc, acc_corr, acc_shift, bcd_reg;
   logic [CNT_W-1:0] cnt;
   logic             last;
   logic             sign;
   logic             sign_reg, neg_reg;

`ifdef BIN2BCD_SIGNED_EN
   // Magnitude of the most negative value wraps to itself, i.e. 2^(WIDTH-1) unsigned.
   assign sign    = value[WIDTH-1];
   assign operand = sign ? (~value + WIDTH'(1)) : value;
   assign neg     = neg_reg;
`else
   assign sign    = 1'b0;
   assign operand = value;
   assign neg     = 1'b0;
`endif

   assign last  = (cnt == CNT_W'(WIDTH - 1));
   assign ready = (state == IDLE);
   assign busy  = ~ready;
   assign valid = (state == DONE);
   assign bcd   = bcd_reg;

   for (genvar g = 0; g < DIGITS; g++) begin : g_corr
      bcd_add3 u_add3 (
         .din  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .dout (acc_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   assign acc_shift = {acc_corr[ACC_W-2:0], bin_reg[WIDTH-1]};

   // NOTE: state_nxt gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: every datapath register is reset so an aborted conversion leaves no stale result behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_reg  <= '0;
         acc      <= '0;
         cnt      <= '0;
         bcd_reg  <= '0;
         sign_reg <= 1'b0;
         neg_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  bin_reg  <= operand;
                  acc      <= '0;
                  cnt      <= '0;
                  sign_reg <= sign;
               end
            end
            SHIFT: begin
               acc     <= acc_shift;
               bin_reg <= bin_reg << 1;
               cnt     <= cnt + CNT_W'(1);
               if (last) begin
                  bcd_reg <= acc_shift;
                  neg_reg <= sign_reg;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, multi-cycle corner sequences,
// and randomized back-to-back traffic against a decimal reference model.
module tb_bin2bcd_seq;

   localparam int WIDTH  = 32;
   localparam int DIGITS = 10;
   localparam int PERIOD = WIDTH + 2;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [WIDTH-1:0]      value;
   logic                  ready, busy, valid, neg;
   logic [4*DIGITS-1:0]   bcd;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [WIDTH-1:0]    v;
      logic [4*DIGITS-1:0] exp_bcd;
      logic                exp_neg;
   } vec_t;

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .value (value),
      .ready (ready),
      .busy  (busy),
      .valid (valid),
      .bcd   (bcd),
      .neg   (neg)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic ref_neg(input logic [WIDTH-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
      return v[WIDTH-1];
`else
      return 1'b0;
`endif
   endfunction

   // Decimal digits by repeated division of the numeric magnitude.
   function automatic logic [4*DIGITS-1:0] ref_bcd(input logic [WIDTH-1:0] v);
      longint unsigned m;
      logic [4*DIGITS-1:0] r;
      m = 64'(v);
`ifdef BIN2BCD_SIGNED_EN
      if (v[WIDTH-1]) m = (64'd1 << WIDTH) - 64'(v);
`endif
      r = '0;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   // Called #1 after an edge while ready=1; returns edges from accept to first valid sample.
   task automatic do_conv(input logic [WIDTH-1:0] v, output int lat);
      start = 1'b1;
      value = v;
      @(posedge clk);
      #1;
      start = 1'b0;
      value = $urandom;
      lat   = 0;
      while (!valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   vec_t vecs[7];
   int   lat;
   int   nvalid, nlow;
   logic [WIDTH-1:0] q[$];
   logic [WIDTH-1:0] v_acc;
   int   last_valid, seen;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      value = '0;

      vecs[0] = '{32'd0,          40'h0,          1'b0};
      vecs[1] = '{32'd1234567890, 40'h1234567890, 1'b0};
      vecs[3] = '{32'd42,         40'h42,         1'b0};
      vecs[4] = '{32'd9,          40'h9,          1'b0};
      vecs[5] = '{32'd10,         40'h10,         1'b0};
`ifdef BIN2BCD_SIGNED_EN
      vecs[2] = '{32'hFFFFFFFF,   40'h1,          1'b1};
      vecs[6] = '{32'h80000000,   40'h2147483648, 1'b1};
`else
      vecs[2] = '{32'hFFFFFFFF,   40'h4294967295, 1'b0};
      vecs[6] = '{32'h80000000,   40'h2147483648, 1'b0};
`endif

      #22;
      check("reset_ready", 64'(ready), 64'd1);
      check("reset_busy",  64'(busy),  64'd0);
      check("reset_valid", 64'(valid), 64'd0);
      check("reset_bcd",   64'(bcd),   64'd0);
      check("reset_neg",   64'(neg),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Vector table
      foreach (vecs[i]) begin
         do_conv(vecs[i].v, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(WIDTH));
         check($sformatf("vec%0d_bcd", i), 64'(bcd), 64'(vecs[i].exp_bcd));
         check($sformatf("vec%0d_neg", i), 64'(neg), 64'(vecs[i].exp_neg));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_pulse_end", i), 64'(valid), 64'd0);
         check($sformatf("vec%0d_ready_back", i), 64'(ready), 64'd1);
      end

      // Starts while busy are dropped; ready low for SHIFT plus DONE cycles
      start = 1'b1;
      value = 32'd100;
      @(posedge clk);
      #1;
      start  = 1'b0;
      nvalid = 0;
      nlow   = (ready == 1'b0) ? 1 : 0;
      for (int c = 1; c <= 40; c++) begin
         if (c == 5 || c == 20) begin
            start = 1'b1;
            value = 32'd7;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (valid) begin
            nvalid++;
            check("busy_start_bcd", 64'(bcd), 64'h100);
         end
         if (!ready) nlow++;
      end
      check("busy_start_nvalid", 64'(nvalid), 64'd1);
      check("busy_start_ready_low", 64'(nlow), 64'(WIDTH + 1));

      // Asynchronous reset mid-conversion
      start = 1'b1;
      value = 32'd999;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy",  64'(busy),  64'd0);
      check("arst_ready", 64'(ready), 64'd1);
      check("arst_bcd",   64'(bcd),   64'd0);
      check("arst_valid", 64'(valid), 64'd0);
      #3;
      rst = 1'b0;
      nvalid = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk);
         #1;
         if (valid) nvalid++;
      end
      check("arst_no_valid", 64'(nvalid), 64'd0);
      do_conv(32'd999, lat);
      check("arst_restart_latency", 64'(lat), 64'(WIDTH));
      check("arst_restart_bcd", 64'(bcd), 64'(ref_bcd(32'd999)));
      @(posedge clk);
      #1;

      // Random single conversions against the reference model
      for (int i = 0; i < 8; i++) begin
         v_acc = $urandom;
         do_conv(v_acc, lat);
         check($sformatf("rand%0d_latency", i), 64'(lat), 64'(WIDTH));
         check($sformatf("rand%0d_bcd", i), 64'(bcd), 64'(ref_bcd(v_acc)));
         check($sformatf("rand%0d_neg", i), 64'(neg), 64'(ref_neg(v_acc)));
         @(posedge clk);
         #1;
      end

      // Back-to-back with start held high and value changing every cycle
      start      = 1'b1;
      value      = $urandom;
      q.push_back(value);
      last_valid = -1;
      seen       = 0;
      for (int c = 0; c < 6 * PERIOD + 4; c++) begin
         @(posedge clk);
         #1;
         if (valid) begin
            if (q.size() == 0) begin
               check("b2b_unexpected_valid", 64'(valid), 64'd0);
            end else begin
               v_acc = q.pop_front();
               check($sformatf("b2b%0d_bcd", seen), 64'(bcd), 64'(ref_bcd(v_acc)));
               check($sformatf("b2b%0d_neg", seen), 64'(neg), 64'(ref_neg(v_acc)));
            end
            if (last_valid >= 0)
               check($sformatf("b2b%0d_interval", seen), 64'(c - last_valid), 64'(PERIOD));
            last_valid = c;
            seen++;
         end
         value = $urandom;
         if (ready) q.push_back(value);
      end
      start = 1'b0;
      check("b2b_count", 64'(seen), 64'd6);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
